// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stage bit
// positions, FSM state encodings and the stall/flush vector constants.
package pipeline_ctrl_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int NUM_STAGES = 5;

    // Bit positions in the stall/flush vectors, upstream first.
    localparam int STAGE_PC     = 0;
    localparam int STAGE_IF_ID  = 1;
    localparam int STAGE_ID_EX  = 2;
    localparam int STAGE_EX_MEM = 3;
    localparam int STAGE_MEM_WB = 4;

    typedef logic [NUM_STAGES-1:0] stage_vec_t;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MDU_WAIT = 2'd1,
        CTRL_MEM_WAIT = 2'd2
    } ctrl_state_t;

    // A stall holds every register upstream of the stage that receives the bubble.
    localparam stage_vec_t STALL_MEM    = stage_vec_t'((1 << STAGE_MEM_WB) - (1 << STAGE_PC)); // 01111
    localparam stage_vec_t FLUSH_MEM    = stage_vec_t'(1 << STAGE_MEM_WB);                     // 10000
    localparam stage_vec_t STALL_MDU    = stage_vec_t'((1 << STAGE_EX_MEM) - (1 << STAGE_PC)); // 00111
    localparam stage_vec_t FLUSH_MDU    = stage_vec_t'(1 << STAGE_EX_MEM);                     // 01000
    localparam stage_vec_t STALL_LU     = stage_vec_t'((1 << STAGE_ID_EX) - (1 << STAGE_PC));  // 00011
    localparam stage_vec_t FLUSH_LU     = stage_vec_t'(1 << STAGE_ID_EX);                      // 00100
    localparam stage_vec_t FLUSH_BRANCH = stage_vec_t'(1 << STAGE_IF_ID);                      // 00010

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently in EX. Register 0 never creates a hazard.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_write_reg,
    output logic                 hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_write_reg);
    assign rt_match = id_uses_rt && (id_rt == ex_write_reg);
    assign hazard   = ex_mem_read && (ex_write_reg != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// stall/flush are Mealy outputs from the registered FSM state and the
// current hazard inputs. Optional performance counters are built only
// when the macro PIPELINE_PERF_CNT_EN is defined; otherwise both
// counter outputs are tied to zero.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_IDX_W-1:0]  id_rs,
    input  logic [REG_IDX_W-1:0]  id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_IDX_W-1:0]  ex_write_reg,
    input  logic                  branch_taken,
    input  logic                  ex_mdu_start,
    input  logic                  mdu_done,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      perf_stall_cycles,
    output logic [CNT_W-1:0]      perf_flushes
);

    localparam int TMAX = (MDU_TIMEOUT > MEM_TIMEOUT) ? MDU_TIMEOUT : MEM_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    // The wait counter holds the number of wait cycles already completed,
    // so the last permitted cycle is the one where it equals TIMEOUT-1.
    localparam logic [TW-1:0] MDU_LIM = TW'(MDU_TIMEOUT - 1);
    localparam logic [TW-1:0] MEM_LIM = TW'(MEM_TIMEOUT - 1);

    ctrl_state_t   state;
    ctrl_state_t   state_next;
    logic [TW-1:0] wait_cnt;
    logic          lu_hazard;
    logic          enter_wait;
    logic          timeout_hit;

    load_use_detect u_load_use_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .hazard       (lu_hazard)
    );

    // FSM state register; reset aborts any wait and returns to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CTRL_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (enter_wait) begin
                wait_cnt <= '0;
            end else if (state != CTRL_RUN) begin
                wait_cnt <= wait_cnt + TW'(1);
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Next-state and Mealy stall/flush decode; RUN applies the hazard priority chain.
    always_comb begin
        stall       = '0;
        flush       = '0;
        state_next  = state;
        enter_wait  = 1'b0;
        timeout_hit = 1'b0;
        if (!rst) begin
            case (state)
                CTRL_RUN: begin
                    if (mem_req && !mem_ready) begin
                        stall      = STALL_MEM;
                        flush      = FLUSH_MEM;
                        state_next = CTRL_MEM_WAIT;
                        enter_wait = 1'b1;
                    end else if (ex_mdu_start) begin
                        // A same-cycle mdu_done cannot belong to this operation.
                        stall      = STALL_MDU;
                        flush      = FLUSH_MDU;
                        state_next = CTRL_MDU_WAIT;
                        enter_wait = 1'b1;
                    end else if (lu_hazard) begin
                        stall = STALL_LU;
                        flush = FLUSH_LU;
                    end else if (branch_taken) begin
                        flush = FLUSH_BRANCH;
                    end
                end
                CTRL_MEM_WAIT: begin
                    if (mem_ready || (wait_cnt == MEM_LIM)) begin
                        // Release: the pipeline advances this edge, so a branch
                        // resolved in ID now squashes the wrong-path fetch.
                        timeout_hit = !mem_ready;
                        state_next  = CTRL_RUN;
                        if (branch_taken) begin
                            flush = FLUSH_BRANCH;
                        end
                    end else begin
                        stall = STALL_MEM;
                        flush = FLUSH_MEM;
                    end
                end
                CTRL_MDU_WAIT: begin
                    if (mdu_done || (wait_cnt == MDU_LIM)) begin
                        timeout_hit = !mdu_done;
                        state_next  = CTRL_RUN;
                        if (branch_taken) begin
                            flush = FLUSH_BRANCH;
                        end
                    end else begin
                        stall = STALL_MDU;
                        flush = FLUSH_MDU;
                    end
                end
                default: begin
                    state_next = CTRL_RUN;
                end
            endcase
        end
    end

    assign busy = !rst && (state != CTRL_RUN);

`ifdef PIPELINE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Free-running wrap-around counters of stalled cycles and branch squashes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (|stall) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush == FLUSH_BRANCH) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cycles = stall_cnt;
    assign perf_flushes      = flush_cnt;
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a stimulus process drives each cycle,
// predicts the response from the hazard rules and queues it; a monitor on
// the falling edge pops and compares.
module tb_pipeline_ctrl;

    localparam int MDU_TO = 16;
    localparam int MEM_TO = 8;
    localparam int CW     = 32;

    localparam int M_RUN = 0;
    localparam int M_MDU = 1;
    localparam int M_MEM = 2;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       ex_mem_read;
        logic [4:0] ex_write_reg;
        logic       branch_taken;
        logic       ex_mdu_start;
        logic       mdu_done;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    typedef struct packed {
        logic [4:0]    stall;
        logic [4:0]    flush;
        logic          busy;
        logic          err;
        logic          chk_regs;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_write_reg;
    logic          id_uses_rs, id_uses_rt, ex_mem_read;
    logic          branch_taken, ex_mdu_start, mdu_done, mem_req, mem_ready;
    logic [4:0]    stall, flush;
    logic          busy, timeout_err;
    logic [CW-1:0] perf_stall_cycles, perf_flushes;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model state
    int            m_mode   = M_RUN;
    int            m_waited = 0;
    logic          m_err    = 1'b0;
    logic [CW-1:0] m_scnt   = '0;
    logic [CW-1:0] m_fcnt   = '0;

    pipeline_ctrl #(
        .MDU_TIMEOUT (MDU_TO),
        .MEM_TIMEOUT (MEM_TO),
        .CNT_W       (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_uses_rs        (id_uses_rs),
        .id_uses_rt        (id_uses_rt),
        .ex_mem_read       (ex_mem_read),
        .ex_write_reg      (ex_write_reg),
        .branch_taken      (branch_taken),
        .ex_mdu_start      (ex_mdu_start),
        .mdu_done          (mdu_done),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .stall             (stall),
        .flush             (flush),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the response the rules require.
    task automatic step(input stim_t s);
        exp_t e;
        logic lu;
        logic done_now;
        int   limit;
        @(posedge clk);
        #1;
        rst          = s.rst;
        id_rs        = s.id_rs;
        id_rt        = s.id_rt;
        id_uses_rs   = s.id_uses_rs;
        id_uses_rt   = s.id_uses_rt;
        ex_mem_read  = s.ex_mem_read;
        ex_write_reg = s.ex_write_reg;
        branch_taken = s.branch_taken;
        ex_mdu_start = s.ex_mdu_start;
        mdu_done     = s.mdu_done;
        mem_req      = s.mem_req;
        mem_ready    = s.mem_ready;

        e          = '0;
        e.chk_regs = !s.rst;
        e.err      = m_err;
        e.scnt     = m_scnt;
        e.fcnt     = m_fcnt;
        e.busy     = !s.rst && (m_mode != M_RUN);

        if (s.rst) begin
            m_mode   = M_RUN;
            m_waited = 0;
            m_err    = 1'b0;
            m_scnt   = '0;
            m_fcnt   = '0;
        end else begin
            lu = s.ex_mem_read && (s.ex_write_reg != 0) &&
                 ((s.id_uses_rs && s.id_rs == s.ex_write_reg) ||
                  (s.id_uses_rt && s.id_rt == s.ex_write_reg));
            if (m_mode == M_RUN) begin
                if (s.mem_req && !s.mem_ready) begin
                    e.stall = 5'b01111; e.flush = 5'b10000;
                    m_mode = M_MEM; m_waited = 0;
                end else if (s.ex_mdu_start) begin
                    e.stall = 5'b00111; e.flush = 5'b01000;
                    m_mode = M_MDU; m_waited = 0;
                end else if (lu) begin
                    e.stall = 5'b00011; e.flush = 5'b00100;
                end else if (s.branch_taken) begin
                    e.flush = 5'b00010;
                end
            end else begin
                done_now = (m_mode == M_MEM) ? s.mem_ready : s.mdu_done;
                limit    = (m_mode == M_MEM) ? MEM_TO : MDU_TO;
                if (done_now || (m_waited + 1 == limit)) begin
                    if (!done_now) m_err = 1'b1;
                    if (s.branch_taken) e.flush = 5'b00010;
                    m_mode = M_RUN;
                end else begin
                    e.stall  = (m_mode == M_MEM) ? 5'b01111 : 5'b00111;
                    e.flush  = (m_mode == M_MEM) ? 5'b10000 : 5'b01000;
                    m_waited = m_waited + 1;
                end
            end
`ifdef PIPELINE_PERF_CNT_EN
            if (e.stall != 0) m_scnt = m_scnt + 1;
            if (e.flush == 5'b00010) m_fcnt = m_fcnt + 1;
`endif
        end
`ifndef PIPELINE_PERF_CNT_EN
        e.scnt = '0;
        e.fcnt = '0;
`endif
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT response mid-cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall", CW'(stall), CW'(e.stall));
            chk("flush", CW'(flush), CW'(e.flush));
            chk("busy", CW'(busy), CW'(e.busy));
            if (e.chk_regs) begin
                chk("timeout_err", CW'(timeout_err), CW'(e.err));
                chk("perf_stall_cycles", perf_stall_cycles, e.scnt);
                chk("perf_flushes", perf_flushes, e.fcnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, expected 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        {id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_write_reg} = '0;
        {branch_taken, ex_mdu_start, mdu_done, mem_req, mem_ready} = '0;

        // Reset, then idle
        s = '0; s.rst = 1'b1;
        repeat (2) step(s);
        s = '0;
        repeat (2) step(s);

        // Load-use on r5, then the same shape on r0 (no hazard)
        s = '0; s.ex_mem_read = 1'b1; s.ex_write_reg = 5'd5; s.id_rs = 5'd5; s.id_uses_rs = 1'b1;
        step(s);
        s = '0; step(s);
        s = '0; s.ex_mem_read = 1'b1; s.ex_write_reg = 5'd0; s.id_rs = 5'd0; s.id_uses_rs = 1'b1;
        step(s);
        s = '0; s.ex_mem_read = 1'b1; s.ex_write_reg = 5'd7; s.id_rt = 5'd7; s.id_uses_rt = 1'b1;
        step(s);

        // MDU op completing 10 cycles after issue
        s = '0; s.ex_mdu_start = 1'b1; step(s);
        s = '0; repeat (9) step(s);
        s = '0; s.mdu_done = 1'b1; step(s);
        s = '0; step(s);

        // Slow memory with a taken branch held in ID
        s = '0; s.mem_req = 1'b1; s.branch_taken = 1'b1;
        repeat (3) step(s);
        s.mem_ready = 1'b1; step(s);
        s = '0; step(s);

        // Memory access that never completes
        s = '0; s.mem_req = 1'b1;
        repeat (9) step(s);
        s = '0; repeat (3) step(s);

        // Reset in the middle of an MDU wait
        s = '0; s.ex_mdu_start = 1'b1; step(s);
        s = '0; repeat (3) step(s);
        s = '0; s.rst = 1'b1; step(s);
        s = '0; repeat (2) step(s);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst          = ($urandom_range(0, 299) == 0);
            s.id_rs        = 5'($urandom_range(0, 3));
            s.id_rt        = 5'($urandom_range(0, 3));
            s.id_uses_rs   = 1'($urandom_range(0, 1));
            s.id_uses_rt   = 1'($urandom_range(0, 1));
            s.ex_mem_read  = 1'($urandom_range(0, 1));
            s.ex_write_reg = 5'($urandom_range(0, 3));
            s.branch_taken = ($urandom_range(0, 2) == 0);
            s.ex_mdu_start = ($urandom_range(0, 9) == 0);
            s.mdu_done     = ($urandom_range(0, 7) == 0);
            s.mem_req      = ($urandom_range(0, 7) == 0);
            s.mem_ready    = (m_mode == M_MEM) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
            step(s);
        end

        s = '0;
        step(s);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", CW'(sb.size()), CW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
